conv4_feeder: RTL
=================

# conv4_feeder

Input sequencer for the 4-row convolution core. Accepts a weight load and a row-major pixel stream for one channel, buffers four image rows in a rotating line buffer, and drives the core's four row inputs, three filter-row inputs and enable, one column beat per cycle. Vertical stride is 2: after each pass the two oldest rows are retired and two new rows are filled.

## Interface
- DATA_W, conv4_width (package `definition`): pixel/weight width
- IMG_W, 16: pixels per row (≥3)
- IMG_H, 16: rows per frame (even, ≥4)
- DRAIN, 4: idle cycles after each pass before `pass_done`, for core pipeline flush

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start  in  1  frame start pulse, honoured only in IDLE
- busy  out  1  high in every state except IDLE
- w_valid  in  1  weight write strobe
- w_addr  in  4  weight index 0..8; row = addr/3, col = addr%3
- w_data  in  DATA_W  weight value
- s_valid  in  1  pixel valid
- s_ready  out  1  pixel accept; high only in FILL
- s_data  in  DATA_W  pixel, row-major
- o_en  out  1  beat valid, to core `en`
- o_r1..o_r4  out  DATA_W each  row samples, oldest row on o_r1
- o_f1..o_f3  out  DATA_W each  filter-row taps W[0..2][k]
- pass_done  out  1  one-cycle pulse at end of each pass
- frame_done  out  1  one-cycle pulse after the last pass

## Operation
- Storage: 3×3 weight registers; 4 row banks of IMG_W words; 2-bit bank pointer `base` (oldest row = bank `base`).
- FSM IDLE → FILL → STREAM → DRAIN → (FILL | IDLE).
- IDLE: weight writes accepted (w_valid with w_addr ≤ 8); w_addr 9..15 ignored. On `start`: base=0, pass=0, fill target = 4 rows, → FILL.
- Weight writes in any state other than IDLE are ignored.
- FILL: s_ready=1; a pixel is accepted when s_valid && s_ready and written to bank (base+row_idx) mod 4 at column col. Target is 4 rows on the first pass and 2 rows (banks base+2, base+3) afterwards. Leaving FILL requires the last pixel of the target to be accepted → STREAM.
- STREAM: beat counter c = 0..N−1, N = IMG_W. Each beat: o_rn = bank[(base+n−1) mod 4][c]; o_fm = W[m−1][c mod 3]; o_en=1. After beat N−1 → DRAIN.
- DRAIN: o_en=0 for DRAIN cycles; last cycle pulses pass_done. Then pass+1. If pass+1 = (IMG_H−4)/2+1 → pulse frame_done together with pass_done, → IDLE; else base = base+2 mod 4, → FILL (target 2 rows).
- `start` outside IDLE is ignored. Pixels presented outside FILL are not consumed (s_ready=0).

## Timing
- Reset: state IDLE; busy, s_ready, o_en, pass_done, frame_done = 0; o_r*/o_f* = 0; counters, base = 0. Weight and line-buffer contents are undefined after reset.
- All outputs are registered. o_en is high for exactly N consecutive cycles per pass, starting the cycle after the FILL→STREAM transition. Data is zero whenever o_en=0.
- First beat is 2 cycles after acceptance of the last fill pixel, assuming continuous s_valid.
- Weight write takes effect the next cycle. A write and `start` in the same cycle: the write is applied first.
- rst mid-frame aborts immediately; no pass_done or frame_done is generated.

## Configuration
- `CONV4_FEEDER_PAD_EN` defined: one zero column of padding on each side. N = IMG_W+2. Beats 0 and N−1 drive o_r1..o_r4 = 0. Beat c reads column c−1. Filter index remains c mod 3.
- Not defined: N = IMG_W, no padding.

## Test plan
- Reset mid-STREAM (IMG_W=4, IMG_H=6) → o_en=0, busy=0, s_ready=0 immediately. No pulses. A new `start` runs normally.
- Weights 1..9 at addr 0..8, pixel p(r,c)=10r+c, IMG_W=4, IMG_H=6 → pass 0 beats: (o_r1..4)=(c,10+c,20+c,30+c); o_f1/o_f2/o_f3 at c=0: 1/4/7, c=1: 2/5/8, c=2: 3/6/9, c=3: 1/4/7.
- Same frame, pass 1 → o_r1..4 = rows 2..5 (20+c..50+c). Exactly 8 pixels are accepted before pass 1. frame_done is coincident with the second pass_done.
- s_valid toggling 1/0 in FILL → only valid&ready beats are stored; beat data matches the gap-free run.
- w_valid with addr 12, and w_valid during STREAM → weights unchanged; `start` in FILL is ignored.
- With CONV4_FEEDER_PAD_EN, IMG_W=4 → 6 beats per pass; beats 0 and 5 have rows 0; beat 1 o_r1=0 (p(0,0)).

Source files
------------

// File: rtl/conv4_feeder.sv
// conv4_feeder: input sequencer for the 4-row convolution core.
// Buffers four image rows in a rotating 4-bank line buffer. Each pass streams
// one column beat per cycle to the core, then retires the two oldest rows
// (vertical stride 2).
// Optional feature: define CONV4_FEEDER_PAD_EN to add one zero column of
// padding on each side of every row.
package definition;
  parameter int conv4_width = 8;
endpackage

module conv4_feeder #(
  parameter int DATA_W = definition::conv4_width,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int DRAIN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic              w_valid,
  input  logic [3:0]        w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              o_en,
  output logic [DATA_W-1:0] o_r1,
  output logic [DATA_W-1:0] o_r2,
  output logic [DATA_W-1:0] o_r3,
  output logic [DATA_W-1:0] o_r4,
  output logic [DATA_W-1:0] o_f1,
  output logic [DATA_W-1:0] o_f2,
  output logic [DATA_W-1:0] o_f3,
  output logic              pass_done,
  output logic              frame_done
);
`ifdef CONV4_FEEDER_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int N      = IMG_W + 2 * PAD;
  localparam int PASSES = (IMG_H - 4) / 2 + 1;
  localparam int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int CW     = $clog2(N + 1);
  localparam int DW     = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam int PW     = $clog2(PASSES + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DRAIN} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] wt   [9];
  logic [DATA_W-1:0] bank [4][IMG_W];
  logic [1:0]        base;
  logic [1:0]        row_idx;
  logic [XW-1:0]     col;
  logic [CW-1:0]     beat;
  logic [1:0]        fidx;
  logic [DW-1:0]     dcnt;
  logic [PW-1:0]     pass_cnt;

  logic              accept, fill_last, beat_last, drain_last, last_pass;
  logic [XW-1:0]     rd_col;
  logic              pad_beat;

  // Handshake and terminal-count decodes
  always_comb begin
    accept     = s_valid && (state == S_FILL);
    fill_last  = accept && (row_idx == 2'd3) && (col == XW'(IMG_W - 1));
    beat_last  = (beat == CW'(N - 1));
    drain_last = (dcnt == DW'(DRAIN - 1));
    last_pass  = (pass_cnt == PW'(PASSES - 1));
    rd_col     = XW'(beat - CW'(PAD));
`ifdef CONV4_FEEDER_PAD_EN
    pad_beat   = (beat == '0) || beat_last;
`else
    pad_beat   = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FILL;
      S_FILL:   if (fill_last) state_next = S_STREAM;
      S_STREAM: if (beat_last) state_next = S_DRAIN;
      S_DRAIN:  if (drain_last) state_next = last_pass ? S_IDLE : S_FILL;
      default:  state_next = S_IDLE;
    endcase
  end

  // Fill position, beat, drain and pass counters; bank pointer rotation.
  // Refills always start at row_idx 2, so every fill ends at row_idx 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base     <= '0;
      row_idx  <= '0;
      col      <= '0;
      beat     <= '0;
      fidx     <= '0;
      dcnt     <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          base     <= '0;
          pass_cnt <= '0;
          row_idx  <= '0;
          col      <= '0;
        end
        S_FILL: if (accept) begin
          if (col == XW'(IMG_W - 1)) begin
            col     <= '0;
            row_idx <= row_idx + 2'd1;
          end else begin
            col <= col + XW'(1);
          end
          beat <= '0;
          fidx <= '0;
        end
        S_STREAM: begin
          beat <= beat_last ? '0 : beat + CW'(1);
          fidx <= (fidx == 2'd2) ? 2'd0 : fidx + 2'd1;
          dcnt <= '0;
        end
        S_DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (drain_last) begin
            pass_cnt <= pass_cnt + PW'(1);
            base     <= base + 2'd2;
            row_idx  <= 2'd2;
            col      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Weight and line-buffer storage (contents not reset)
  always_ff @(posedge clk) begin
    if (state == S_IDLE && w_valid && w_addr < 4'd9) wt[w_addr] <= w_data;
    if (accept) bank[base + row_idx][col] <= s_data;
  end

  // Registered outputs; data held at zero whenever o_en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      s_ready    <= 1'b0;
      o_en       <= 1'b0;
      o_r1       <= '0;
      o_r2       <= '0;
      o_r3       <= '0;
      o_r4       <= '0;
      o_f1       <= '0;
      o_f2       <= '0;
      o_f3       <= '0;
      pass_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      busy       <= (state_next != S_IDLE);
      s_ready    <= (state_next == S_FILL);
      o_en       <= 1'b0;
      o_r1       <= '0;
      o_r2       <= '0;
      o_r3       <= '0;
      o_r4       <= '0;
      o_f1       <= '0;
      o_f2       <= '0;
      o_f3       <= '0;
      pass_done  <= 1'b0;
      frame_done <= 1'b0;
      if (state == S_STREAM) begin
        o_en <= 1'b1;
        if (!pad_beat) begin
          o_r1 <= bank[base][rd_col];
          o_r2 <= bank[base + 2'd1][rd_col];
          o_r3 <= bank[base + 2'd2][rd_col];
          o_r4 <= bank[base + 2'd3][rd_col];
        end
        o_f1 <= wt[{2'b00, fidx}];
        o_f2 <= wt[{2'b00, fidx} + 4'd3];
        o_f3 <= wt[{2'b00, fidx} + 4'd6];
      end
      if (state == S_DRAIN && drain_last) begin
        pass_done  <= 1'b1;
        frame_done <= last_pass;
      end
    end
  end

endmodule
